// File: rtl/rocketcpu_busctrl.sv
// ----------------------------------------------------------------------------
// rocketcpu_busctrl
//
// Wishbone bus controller between the arbiter master port and the SoC slaves.
// The block decodes the master address into a registered one-hot slave
// select. It sequences each access and registers the read-data mux into the
// master ack cycle. A watchdog ends unmapped or hung accesses with an error
// ack, so the CPU never stalls forever. The first failing access is recorded
// in a sticky error register, which can also serve as an interrupt.
//
// Ports
//   i_wb_clk   system clock
//   reset_n    asynchronous active-low reset
//   i_wb_adr   master address
//   i_wb_cyc   master cycle request
//   i_wb_we    master write enable (used only to tag errors)
//   o_wb_rdt   read data to master, valid while o_wb_ack=1
//   o_wb_ack   single-cycle ack to master
//   o_slv_cyc  one-hot slave select: 0 flash, 1 ram, 2 gpio, 3 uart,
//              4 timer, 5 audio
//   i_slv_rdt  packed slave read data, slot n on bits [32n+31:32n]
//   i_slv_ack  slave acks (ignored for ACK_MASK slots)
//   i_err_clr  clears the sticky error flag
//   o_err      sticky bus-error flag
//   o_err_adr  address of the first errored access since the last clear
//   o_err_we   write enable of that access
// ----------------------------------------------------------------------------
module rocketcpu_busctrl #(
    parameter int unsigned TIMEOUT  = 255,           // 1..65535 ACTIVE cycles
    parameter logic [5:0]  ACK_MASK = 6'b010100,     // slots acked internally
    parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF  // read data on error
) (
    input  logic         i_wb_clk,
    input  logic         reset_n,
    input  logic [31:0]  i_wb_adr,
    input  logic         i_wb_cyc,
    input  logic         i_wb_we,
    output logic [31:0]  o_wb_rdt,
    output logic         o_wb_ack,
    output logic [5:0]   o_slv_cyc,
    input  logic [191:0] i_slv_rdt,
    input  logic [5:0]   i_slv_ack,
    input  logic         i_err_clr,
    output logic         o_err,
    output logic [31:0]  o_err_adr,
    output logic         o_err_we
);

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        RESP,
        ERR
    } state_t;

    // Last counter value before the watchdog fires; the counter saturates here.
    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [15:0] cnt_q;
    logic [31:0] adr_q;
    logic        we_q;

    logic [5:0]  dec_sel;
    logic        mapped;
    logic [31:0] slot_rdt;
    logic        slot_ack;
    logic        enter_err;

    // ------------------------------------------------------------------------
    // Address decode (only consumed in IDLE)
    // ------------------------------------------------------------------------
    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        dec_sel = '0;
        if (i_wb_adr < 32'h0000_8000)
            dec_sel[1] = 1'b1;
        else if (i_wb_adr >= 32'h0010_0000 && i_wb_adr < 32'h0200_0000)
            dec_sel[0] = 1'b1;
        else if (i_wb_adr == 32'h0200_0000)
            dec_sel[2] = 1'b1;
        else if (i_wb_adr == 32'h0400_0000)
            dec_sel[3] = 1'b1;
        else if (i_wb_adr == 32'h0800_0000)
            dec_sel[4] = 1'b1;
        else if (i_wb_adr >= 32'h1000_0000)
            dec_sel[5] = 1'b1;
    end

    assign mapped = |dec_sel;

    // ------------------------------------------------------------------------
    // Selected-slot read data and ack. The select is one-hot, so OR-ing the
    // gated slices gives a plain mux. Slots in ACK_MASK have no ack output,
    // so they count as acked on their first select cycle.
    // ------------------------------------------------------------------------
    always_comb begin
        slot_rdt = '0;
        for (int i = 0; i < 6; i++) begin
            if (o_slv_cyc[i])
                slot_rdt = slot_rdt | i_slv_rdt[32*i +: 32];
        end
    end

    assign slot_ack = |(o_slv_cyc & (ACK_MASK | i_slv_ack));

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (i_wb_cyc)
                    state_d = mapped ? ACTIVE : ERR;
            end
            ACTIVE: begin
                // The ack is checked before the timeout, so an ack that
                // arrives on the last allowed cycle still completes normally.
                if (slot_ack)
                    state_d = RESP;
                else if (!i_wb_cyc)
                    state_d = IDLE;
                else if (cnt_q == CNT_LAST)
                    state_d = ERR;
            end
            RESP:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ERR is left after one cycle, so a next state of ERR always means entry.
    assign enter_err = (state_d == ERR);

    // ------------------------------------------------------------------------
    // State, select, watchdog counter and master response
    // ------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments, so every register
    // samples the values from before the edge.
    always_ff @(posedge i_wb_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            o_slv_cyc <= '0;
            cnt_q     <= '0;
            o_wb_ack  <= 1'b0;
            o_wb_rdt  <= '0;
            adr_q     <= '0;
            we_q      <= 1'b0;
        end else begin
            state_q  <= state_d;
            o_wb_ack <= (state_d == RESP) || (state_d == ERR);

            if (state_q == IDLE && state_d == ACTIVE)
                o_slv_cyc <= dec_sel;
            else if (state_d != ACTIVE)
                o_slv_cyc <= '0;

            if (state_q != ACTIVE)
                cnt_q <= '0;
            else if (cnt_q != CNT_LAST)
                cnt_q <= cnt_q + 16'd1;

            if (state_d == RESP)
                o_wb_rdt <= slot_rdt;
            else if (state_d == ERR)
                o_wb_rdt <= ERR_DATA;

            // Keep the request tag so a later watchdog error can report it.
            if (state_q == IDLE && i_wb_cyc) begin
                adr_q <= i_wb_adr;
                we_q  <= i_wb_we;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Sticky error record. A new error beats a simultaneous clear. The capture
    // is taken only when no earlier error is still pending.
    // ------------------------------------------------------------------------
    always_ff @(posedge i_wb_clk or negedge reset_n) begin
        if (!reset_n) begin
            o_err     <= 1'b0;
            o_err_adr <= '0;
            o_err_we  <= 1'b0;
        end else if (enter_err) begin
            o_err <= 1'b1;
            if (!o_err || i_err_clr) begin
                // An unmapped access errors straight from IDLE, before adr_q
                // has been loaded.
                o_err_adr <= (state_q == IDLE) ? i_wb_adr : adr_q;
                o_err_we  <= (state_q == IDLE) ? i_wb_we  : we_q;
            end
        end else if (i_err_clr) begin
            o_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rocketcpu_busctrl.sv
// ----------------------------------------------------------------------------
// Directed testbench for rocketcpu_busctrl (TIMEOUT=8). Each step starts 1 ns
// after a rising edge. Inputs are driven at that point and outputs are
// compared there. Cycle numbers in the comments count from the cycle in
// which i_wb_cyc is raised, which is cycle 0.
// ----------------------------------------------------------------------------
module tb_rocketcpu_busctrl;

    logic         i_wb_clk;
    logic         reset_n;
    logic [31:0]  i_wb_adr;
    logic         i_wb_cyc;
    logic         i_wb_we;
    logic [31:0]  o_wb_rdt;
    logic         o_wb_ack;
    logic [5:0]   o_slv_cyc;
    logic [191:0] i_slv_rdt;
    logic [5:0]   i_slv_ack;
    logic         i_err_clr;
    logic         o_err;
    logic [31:0]  o_err_adr;
    logic         o_err_we;

    int n_checks = 0;
    int n_errors = 0;

    rocketcpu_busctrl #(
        .TIMEOUT  (8),
        .ACK_MASK (6'b010100),
        .ERR_DATA (32'hDEAD_BEEF)
    ) dut (
        .i_wb_clk  (i_wb_clk),
        .reset_n   (reset_n),
        .i_wb_adr  (i_wb_adr),
        .i_wb_cyc  (i_wb_cyc),
        .i_wb_we   (i_wb_we),
        .o_wb_rdt  (o_wb_rdt),
        .o_wb_ack  (o_wb_ack),
        .o_slv_cyc (o_slv_cyc),
        .i_slv_rdt (i_slv_rdt),
        .i_slv_ack (i_slv_ack),
        .i_err_clr (i_err_clr),
        .o_err     (o_err),
        .o_err_adr (o_err_adr),
        .o_err_we  (o_err_we)
    );

    initial i_wb_clk = 1'b0;
    always #5 i_wb_clk = ~i_wb_clk;

    task automatic tick();
        @(posedge i_wb_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    initial begin
        reset_n   = 1'b0;
        i_wb_adr  = '0;
        i_wb_cyc  = 1'b0;
        i_wb_we   = 1'b0;
        i_slv_rdt = '0;
        i_slv_ack = '0;
        i_err_clr = 1'b0;

        // ---------------- reset state ----------------
        tick();
        tick();
        check("rst_sel",     32'(o_slv_cyc), 32'h0);
        check("rst_ack",     32'(o_wb_ack),  32'h0);
        check("rst_rdt",     o_wb_rdt,       32'h0);
        check("rst_err",     32'(o_err),     32'h0);
        check("rst_err_adr", o_err_adr,      32'h0);
        check("rst_err_we",  32'(o_err_we),  32'h0);
        reset_n = 1'b1;
        tick();

        // ---------------- ram read, slave acks in cycle 1 ----------------
        i_wb_adr = 32'h0000_0010; i_wb_we = 1'b0; i_wb_cyc = 1'b1;   // c0
        tick();                                                       // c1
        check("ram_sel",     32'(o_slv_cyc), 32'h02);
        check("ram_ack_c1",  32'(o_wb_ack),  32'h0);
        i_slv_rdt[63:32] = 32'h1234_5678;
        i_slv_ack[1]     = 1'b1;
        tick();                                                       // c2
        check("ram_ack",     32'(o_wb_ack),  32'h1);
        check("ram_rdt",     o_wb_rdt,       32'h1234_5678);
        check("ram_err",     32'(o_err),     32'h0);
        check("ram_sel_c2",  32'(o_slv_cyc), 32'h0);
        i_slv_ack = '0;
        tick();                                                       // c3 idle
        i_wb_cyc = 1'b0;
        check("ram_ack_c3",  32'(o_wb_ack),  32'h0);
        tick();

        // ---------------- gpio read, internal ack ----------------
        i_wb_adr = 32'h0200_0000; i_slv_rdt[95:64] = 32'h0000_0001; i_wb_cyc = 1'b1;
        tick();                                                       // c1
        check("gpio_sel",    32'(o_slv_cyc), 32'h04);
        check("gpio_ack_c1", 32'(o_wb_ack),  32'h0);
        tick();                                                       // c2
        check("gpio_ack",    32'(o_wb_ack),  32'h1);
        check("gpio_rdt",    o_wb_rdt,       32'h0000_0001);
        check("gpio_sel_c2", 32'(o_slv_cyc), 32'h0);
        tick();
        i_wb_cyc = 1'b0;
        check("gpio_ack_c3", 32'(o_wb_ack),  32'h0);
        tick();

        // ---------------- unmapped write ----------------
        i_wb_adr = 32'h0300_0000; i_wb_we = 1'b1; i_wb_cyc = 1'b1;
        tick();                                                       // c1
        check("unm_ack",     32'(o_wb_ack),  32'h1);
        check("unm_rdt",     o_wb_rdt,       32'hDEAD_BEEF);
        check("unm_sel",     32'(o_slv_cyc), 32'h0);
        check("unm_err",     32'(o_err),     32'h1);
        check("unm_err_adr", o_err_adr,      32'h0300_0000);
        check("unm_err_we",  32'(o_err_we),  32'h1);
        tick();
        i_wb_cyc = 1'b0; i_wb_we = 1'b0;
        check("unm_ack_c2",  32'(o_wb_ack),  32'h0);
        tick();
        i_err_clr = 1'b1;
        tick();
        i_err_clr = 1'b0;
        check("clr_err",     32'(o_err),     32'h0);

        // ---------------- flash timeout (TIMEOUT=8) ----------------
        i_wb_adr = 32'h0010_0000; i_wb_cyc = 1'b1;                   // c0
        for (int c = 1; c <= 8; c++) begin
            tick();
            check("to_sel",  32'(o_slv_cyc), 32'h01);
            check("to_noack", 32'(o_wb_ack), 32'h0);
        end
        tick();                                                       // c9
        check("to_ack",      32'(o_wb_ack),  32'h1);
        check("to_rdt",      o_wb_rdt,       32'hDEAD_BEEF);
        check("to_sel_c9",   32'(o_slv_cyc), 32'h0);
        check("to_err",      32'(o_err),     32'h1);
        check("to_err_adr",  o_err_adr,      32'h0010_0000);
        check("to_err_we",   32'(o_err_we),  32'h0);
        tick();
        i_wb_cyc = 1'b0;
        tick();
        i_wb_adr = 32'h0300_0004; i_wb_we = 1'b1; i_wb_cyc = 1'b1;
        tick();
        check("err2_ack",    32'(o_wb_ack),  32'h1);
        check("err2_adr",    o_err_adr,      32'h0010_0000);
        check("err2_we",     32'(o_err_we),  32'h0);
        tick();
        i_wb_cyc = 1'b0; i_wb_we = 1'b0;
        tick();

        // ---------------- uart abort ----------------
        i_wb_adr = 32'h0400_0000; i_wb_cyc = 1'b1;                   // c0
        tick();                                                       // c1
        check("abt_sel",     32'(o_slv_cyc), 32'h08);
        tick();                                                       // c2
        tick();                                                       // c3
        i_wb_cyc = 1'b0;
        tick();                                                       // c4
        check("abt_sel_c4",  32'(o_slv_cyc), 32'h0);
        check("abt_ack_c4",  32'(o_wb_ack),  32'h0);
        tick();                                                       // c5
        check("abt_ack_c5",  32'(o_wb_ack),  32'h0);
        // clear together with a new unmapped access: the new error wins
        i_err_clr = 1'b1; i_wb_adr = 32'h0500_0000; i_wb_we = 1'b0; i_wb_cyc = 1'b1;
        tick();
        i_err_clr = 1'b0;
        check("clrw_ack",    32'(o_wb_ack),  32'h1);
        check("clrw_err",    32'(o_err),     32'h1);
        check("clrw_adr",    o_err_adr,      32'h0500_0000);
        check("clrw_we",     32'(o_err_we),  32'h0);
        tick();
        i_wb_cyc = 1'b0;
        tick();
        i_err_clr = 1'b1;
        tick();
        i_err_clr = 1'b0;
        check("clr2_err",    32'(o_err),     32'h0);
        check("clr2_adr",    o_err_adr,      32'h0500_0000);

        // ---------------- ram ack on the last watchdog cycle: ack wins -------
        i_wb_adr = 32'h0000_0020; i_slv_rdt[63:32] = 32'h0BAD_F00D; i_wb_cyc = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            tick();
            check("edge_sel", 32'(o_slv_cyc), 32'h02);
        end
        tick();                                                       // c8
        check("edge_sel_c8", 32'(o_slv_cyc), 32'h02);
        i_slv_ack[1] = 1'b1;
        tick();                                                       // c9
        i_slv_ack = '0;
        check("edge_ack",    32'(o_wb_ack),  32'h1);
        check("edge_rdt",    o_wb_rdt,       32'h0BAD_F00D);
        check("edge_err",    32'(o_err),     32'h0);
        tick();
        i_wb_cyc = 1'b0;
        tick();

        // ---------------- audio, slave acks in cycle 2 ----------------
        i_wb_adr = 32'h1000_0000; i_slv_rdt[191:160] = 32'hA5A5_0001; i_wb_cyc = 1'b1;
        tick();                                                       // c1
        check("aud_sel",     32'(o_slv_cyc), 32'h20);
        check("aud_ack_c1",  32'(o_wb_ack),  32'h0);
        tick();                                                       // c2
        check("aud_ack_c2",  32'(o_wb_ack),  32'h0);
        i_slv_ack[5] = 1'b1;
        tick();                                                       // c3
        i_slv_ack = '0;
        check("aud_ack",     32'(o_wb_ack),  32'h1);
        check("aud_rdt",     o_wb_rdt,       32'hA5A5_0001);
        tick();
        i_wb_cyc = 1'b0;
        tick();

        // ---------------- boundary: first address above ram ----------------
        i_wb_adr = 32'h0000_8000; i_wb_cyc = 1'b1;
        tick();
        check("bnd_ack",     32'(o_wb_ack),  32'h1);
        check("bnd_rdt",     o_wb_rdt,       32'hDEAD_BEEF);
        check("bnd_sel",     32'(o_slv_cyc), 32'h0);
        check("bnd_err",     32'(o_err),     32'h1);
        check("bnd_err_adr", o_err_adr,      32'h0000_8000);
        tick();
        i_wb_cyc = 1'b0;
        tick();

        // ---------------- reset mid-ACTIVE ----------------
        i_wb_adr = 32'h0400_0000; i_wb_cyc = 1'b1;
        tick();                                                       // c1
        check("rsta_sel",    32'(o_slv_cyc), 32'h08);
        tick();                                                       // c2
        #2;
        reset_n = 1'b0;
        #1;
        check("rsta_sel0",   32'(o_slv_cyc), 32'h0);
        check("rsta_ack0",   32'(o_wb_ack),  32'h0);
        check("rsta_err0",   32'(o_err),     32'h0);
        check("rsta_adr0",   o_err_adr,      32'h0);
        i_wb_cyc = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            check("rsta_noack", 32'(o_wb_ack),  32'h0);
            check("rsta_nosel", 32'(o_slv_cyc), 32'h0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/rocketcpu_busctrl.md
Name: rocketcpu_busctrl

Overview:
- Wishbone bus controller between the ibus/dbus arbiter master port and the SoC slaves: flash, RAM, GPIO, UART, timer and audio registers.
- Decodes the address and drives a registered one-hot slave select.
- Sequences each access, registers the read-data mux and generates the master ack.
- A watchdog terminates unmapped or hung accesses with an error response, so the CPU never stalls forever.

Parameters:
- TIMEOUT, 255: cycles in ACTIVE without slave ack before error termination; legal range 1..65535.
- ACK_MASK, 6'b010100: slots whose slaves have no ack output (GPIO, timer); these are acked after one select cycle.
- ERR_DATA, 32'hDEAD_BEEF: read data returned on error termination.

Ports:
- i_wb_clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- i_wb_adr  in  32  master address.
- i_wb_cyc  in  1  master cycle request.
- i_wb_we  in  1  master write enable; used only to tag errors.
- o_wb_rdt  out  32  read data to master; valid only while o_wb_ack=1.
- o_wb_ack  out  1  single-cycle ack to master.
- o_slv_cyc  out  6  one-hot slave select. Slots: 0 flash, 1 ram, 2 gpio, 3 uart, 4 timer, 5 audio.
- i_slv_rdt  in  192  packed slave read data; slot n is bits [32n+31:32n].
- i_slv_ack  in  6  slave acks; ignored for ACK_MASK slots.
- i_err_clr  in  1  clears the sticky error state.
- o_err  out  1  sticky bus-error flag; usable as an interrupt.
- o_err_adr  out  32  address of the first errored access since the last clear.
- o_err_we  out  1  we of that access.

Behaviour:
- Reset:
  - Asserting reset_n=0 forces state IDLE, o_slv_cyc=0, o_wb_ack=0, o_wb_rdt=0, o_err=0, o_err_adr=0, o_err_we=0, and the counter to 0.
  - Reset is effective immediately, including mid-access.
  - No ack is issued for an access interrupted by reset.
- Address map, decoded from i_wb_adr in IDLE:
  - flash: 0x0010_0000 ≤ adr < 0x0200_0000.
  - ram: adr < 0x0000_8000.
  - gpio: adr == 0x0200_0000.
  - uart: adr == 0x0400_0000.
  - timer: adr == 0x0800_0000.
  - audio: adr ≥ 0x1000_0000.
  - Any other address is unmapped.
- The block drives only select, ack and rdt. Address, write data, byte select and we go to the slaves directly from the arbiter.
- State machine: IDLE, ACTIVE, RESP, ERR.
  - IDLE: o_slv_cyc=0, counter cleared. On i_wb_cyc=1:
    - mapped address: register the one-hot select, go to ACTIVE;
    - unmapped address: latch the error info, go to ERR.
  - ACTIVE: o_slv_cyc=sel_q, counter increments by 1 each cycle.
    - If the selected slot is in ACK_MASK, or i_slv_ack[slot]=1: latch that slot's rdt into o_wb_rdt, go to RESP.
    - Else if i_wb_cyc=0 (abort): go to IDLE with no ack.
    - Else if counter == TIMEOUT-1 (i.e. TIMEOUT ACTIVE cycles elapsed): go to ERR.
    - Ack and timeout in the same cycle: ack wins.
  - RESP: o_wb_ack=1 for exactly one cycle, o_slv_cyc=0, then IDLE.
  - ERR: o_wb_ack=1 and o_wb_rdt=ERR_DATA for one cycle, o_slv_cyc=0, then IDLE.
- Error recording:
  - On entry to ERR: set o_err=1.
  - If o_err was 0, also capture o_err_adr and o_err_we. Later errors do not overwrite the capture until cleared.
- Error clear:
  - i_err_clr=1 clears o_err.
  - If an error is recorded in the same cycle as i_err_clr, the new error wins: o_err stays 1 and the new address is captured.
- Latency, counted from i_wb_cyc rising at cycle 0:
  - ACK_MASK slot: select in cycle 1, ack in cycle 2.
  - Acked slot with slave ack in cycle k≥1: ack in cycle k+1.
  - Unmapped address: ack in cycle 1.
  - Timeout: ack in cycle TIMEOUT+1.
- Back-to-back accesses: the master drops cyc in the cycle after ack. A new cyc sampled in IDLE starts a fresh decode, with at least one IDLE cycle between accesses.
- o_wb_rdt holds its last value outside ack cycles; the verifier checks it only when o_wb_ack=1.
- The counter is 16 bits; it cannot wrap because the count saturates at TIMEOUT-1.

Test Plan:
- Read of 0x0000_0010 (ram, slave acks in cycle 1 with 0x1234_5678) -> o_slv_cyc=6'b000010 in cycle 1; o_wb_ack=1, o_wb_rdt=0x1234_5678 in cycle 2; o_err=0.
- Read of 0x0200_0000 (gpio, no ack, rdt=0x1) -> select 6'b000100 for exactly one cycle; ack with rdt=0x1 in cycle 2.
- Write to 0x0300_0000 (unmapped) -> no select; ack with 0xDEAD_BEEF in cycle 1; o_err=1, o_err_adr=0x0300_0000, o_err_we=1.
- Flash access with slave never acking, TIMEOUT=8 -> select held for cycles 1..8; error ack in cycle 9; o_err=1. A second unmapped error to 0x0300_0004 leaves o_err_adr=0x0010_0000.
- Abort: uart access with cyc dropped in cycle 3 before ack -> select cleared in cycle 4, no ack. Then assert i_err_clr together with a new unmapped access -> o_err stays 1 with the new address captured.
- reset_n pulsed low mid-ACTIVE -> o_slv_cyc, o_wb_ack and o_err drop to 0 immediately, with no ack after release.
